eea_ctrl: RTL and testbench
===========================

Name: eea_ctrl

Overview:
- Sequencing controller for the a*x + b*y shift-and-add datapath.
- Accepts operands a and b with a start/done handshake.
- Drives the datapath strobes: plx, ply, shiftx, shifty, sel, incxy, plrez and clrrez.
- Steps the datapath through a load phase, an X accumulate phase over the bits of a, and a Y accumulate phase over the bits of b, then reports completion on status.

Parameters:
- WIDTH, 8, operand width; also the number of bit iterations per phase.
- SKIP_ZERO, 0, when 1 a phase ends early once all remaining higher operand bits are zero.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplier for x; captured when start is accepted.
- b  input  WIDTH  multiplier for y; captured when start is accepted.
- ready  output  1  high in IDLE.
- done  output  1  one-cycle pulse in DONE.
- plx  output  1  parallel load of the X shift register.
- ply  output  1  parallel load of the Y shift register.
- shiftx  output  1  shift X left by one.
- shifty  output  1  shift Y left by one.
- sel  output  1  mux select: 0 selects X, 1 selects Y.
- incxy  output  1  increment of the datapath iteration counter.
- plrez  output  1  load result register with sum.
- clrrez  output  1  synchronous clear of the result register.
- status  output  5  one-hot state: [0] IDLE, [1] LOAD, [2] ADD_X, [3] ADD_Y, [4] DONE.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE, cnt=0, a_q=0, b_q=0.
  - All strobes 0, done=0, ready=1, status=5'b00001.
- All outputs are combinational decodes of state, cnt, a_q and b_q. No output depends combinationally on start, a or b.
- Internal counter cnt has $clog2(WIDTH) bits.
- IDLE:
  - ready=1; all strobes 0.
  - If start=1 at an edge: a_q<=a, b_q<=b, go to LOAD.
- LOAD (1 cycle): plx=1, ply=1, clrrez=1, incxy=0; cnt<=0; go to ADD_X.
- ADD_X:
  - sel=0, shiftx=1, incxy=1, plrez=a_q[cnt].
  - The result register samples the pre-shift outx at the same edge the shift occurs.
  - Exit when cnt==WIDTH-1, or when SKIP_ZERO=1 and (a_q>>(cnt+1))==0.
  - On exit: cnt<=0, go to ADD_Y. Otherwise cnt<=cnt+1.
- ADD_Y:
  - Same rules as ADD_X, with sel=1, shifty=1 and plrez=b_q[cnt].
  - Exit goes to DONE.
- DONE (1 cycle): done=1, all strobes 0; go to IDLE.
- Each phase lasts at least 1 cycle, even for a zero operand.
- Latency, with start sampled at edge k:
  - SKIP_ZERO=0: done is high in the cycle after edge k+17 (fixed 2*WIDTH+2 cycles).
  - SKIP_ZERO=1: LOAD + nx + ny + DONE cycles, where nx = max(1, index of MSB set in a + 1) and ny is defined the same way for b.
- start while not IDLE is ignored; no queuing.
- start held high through DONE launches a new operation at the edge leaving DONE's successor IDLE cycle. Back-to-back throughput is one operation per latency+1 cycles.
- a and b may change freely after acceptance; only a_q and b_q are used.
- Never assert shiftx and shifty together, plx with any shift, or plrez outside ADD_X/ADD_Y.
- status is always exactly one-hot.

Test Plan:
- Reset values:
  - Stimulus: assert reset for 2 cycles, with start=1 during reset.
  - Required: ready=1, status=5'b00001, all strobes 0; no transition until reset deasserts.
- Basic sequence, SKIP_ZERO=0:
  - Stimulus: a=3, b=5.
  - Required strobes: LOAD with plx=ply=clrrez=1.
  - plrez over the 8 ADD_X cycles: 1,1,0,0,0,0,0,0.
  - plrez over the 8 ADD_Y cycles: 1,0,1,0,0,0,0,0.
  - done pulses exactly 18 cycles after acceptance.
  - With a datapath model (x=10, y=20) the final result is 130.
- Full-width operands:
  - Stimulus: a=8'hFF, b=8'h80.
  - Required: plrez high for all 8 ADD_X cycles and only on the 8th ADD_Y cycle.
  - With x=1, y=1 the result is 383.
- SKIP_ZERO=1:
  - Stimulus a=0, b=0: ADD_X and ADD_Y last 1 cycle each; done 4 cycles after acceptance.
  - Stimulus a=8'h01, b=8'h80: ADD_X lasts 1 cycle, ADD_Y lasts 8 cycles.
- Ignored start: pulse start with new a, b mid-ADD_X. Required: sequence and plrez pattern unchanged; no extra LOAD.
- Reset mid-operation: assert reset during ADD_Y cycle 3. Required: status=5'b00001 immediately (asynchronous) and no done pulse; the next start runs a clean full sequence.

Source files
------------

// File: rtl/eea_ctrl.sv
// Sequencer for the a*x + b*y shift-and-add datapath: load, accumulate over
// the bits of a (X phase), then over the bits of b (Y phase), then report done.
module eea_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SKIP_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             plx,
  output logic             ply,
  output logic             shiftx,
  output logic             shifty,
  output logic             sel,
  output logic             incxy,
  output logic             plrez,
  output logic             clrrez,
  output logic [4:0]       status
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD_X,
    S_ADD_Y,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             last_x, last_y;

  // State, iteration counter and captured operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  // Phase end: last bit reached, or (optionally) no set bits remain above cnt
  always_comb begin
    last_x = (cnt == CW'(WIDTH - 1));
    last_y = last_x;
    if (SKIP_ZERO) begin
      last_x = last_x || ((a_q >> (32'(cnt) + 32'd1)) == '0);
      last_y = last_y || ((b_q >> (32'(cnt) + 32'd1)) == '0);
    end
  end

  // Next state and strobe decode
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    a_d     = a_q;
    b_d     = b_q;
    ready   = 1'b0;
    done    = 1'b0;
    plx     = 1'b0;
    ply     = 1'b0;
    shiftx  = 1'b0;
    shifty  = 1'b0;
    sel     = 1'b0;
    incxy   = 1'b0;
    plrez   = 1'b0;
    clrrez  = 1'b0;
    status  = 5'b00001;

    case (state)
      S_IDLE: begin
        ready  = 1'b1;
        status = 5'b00001;
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        status  = 5'b00010;
        plx     = 1'b1;
        ply     = 1'b1;
        clrrez  = 1'b1;
        cnt_d   = '0;
        state_d = S_ADD_X;
      end
      S_ADD_X: begin
        status = 5'b00100;
        shiftx = 1'b1;
        incxy  = 1'b1;
        plrez  = a_q[cnt];
        if (last_x) begin
          cnt_d   = '0;
          state_d = S_ADD_Y;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_ADD_Y: begin
        status = 5'b01000;
        sel    = 1'b1;
        shifty = 1'b1;
        incxy  = 1'b1;
        plrez  = b_q[cnt];
        if (last_y) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_DONE: begin
        status  = 5'b10000;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_eea_ctrl.sv
// Bench for eea_ctrl: one instance per SKIP_ZERO setting, each driving a small
// x/y/result datapath model; per-cycle strobes and final results checked.
module tb_eea_ctrl;

  logic clk;
  logic reset;
  logic [1:0]       start_v;
  logic [1:0][7:0]  a_v, b_v;
  logic [1:0]       ready_v, done_v, plx_v, ply_v, shiftx_v, shifty_v;
  logic [1:0]       sel_v, incxy_v, plrez_v, clrrez_v;
  logic [1:0][4:0]  status_v;

  logic [1:0][31:0] x0, y0, xr, yr, rez;

  logic        plrez_q[$];
  logic [31:0] res_q[$];
  int checks = 0;
  int errors = 0;

  eea_ctrl #(.WIDTH(8), .SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .ready(ready_v[0]), .done(done_v[0]), .plx(plx_v[0]), .ply(ply_v[0]),
    .shiftx(shiftx_v[0]), .shifty(shifty_v[0]), .sel(sel_v[0]),
    .incxy(incxy_v[0]), .plrez(plrez_v[0]), .clrrez(clrrez_v[0]),
    .status(status_v[0])
  );

  eea_ctrl #(.WIDTH(8), .SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .ready(ready_v[1]), .done(done_v[1]), .plx(plx_v[1]), .ply(ply_v[1]),
    .shiftx(shiftx_v[1]), .shifty(shifty_v[1]), .sel(sel_v[1]),
    .incxy(incxy_v[1]), .plrez(plrez_v[1]), .clrrez(clrrez_v[1]),
    .status(status_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: result samples the pre-shift register at the shift edge
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (plx_v[i]) xr[i] <= x0[i];
      else if (shiftx_v[i]) xr[i] <= xr[i] << 1;
      if (ply_v[i]) yr[i] <= y0[i];
      else if (shifty_v[i]) yr[i] <= yr[i] << 1;
      if (clrrez_v[i]) rez[i] <= '0;
      else if (plrez_v[i]) rez[i] <= rez[i] + (sel_v[i] ? yr[i] : xr[i]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [13:0] obs_vec(input int i);
    return {status_v[i], ready_v[i], done_v[i], plx_v[i], ply_v[i], shiftx_v[i],
            shifty_v[i], incxy_v[i], plrez_v[i], clrrez_v[i], sel_v[i]};
  endfunction

  // ph: 0 IDLE, 1 LOAD, 2 ADD_X, 3 ADD_Y, 4 DONE
  function automatic logic [13:0] exp_vec(input int ph, input logic pr);
    logic [4:0] st;
    st = 5'(1 << ph);
    return {st, ph == 0, ph == 4, ph == 1, ph == 1, ph == 2, ph == 3,
            (ph == 2) || (ph == 3), pr, ph == 1, ph == 3};
  endfunction

  task automatic run_op(input int i, input logic [7:0] av, input logic [7:0] bv,
                        input logic [31:0] xv, input logic [31:0] yv,
                        input bit ign, input bit rst_mid, input string name);
    int nx, ny, tot, ph;
    logic pr;
    logic [31:0] er;
    nx = 8;
    ny = 8;
    if (i == 1) begin
      nx = 1;
      ny = 1;
      for (int k = 0; k < 8; k++) begin
        if (av[k]) nx = k + 1;
        if (bv[k]) ny = k + 1;
      end
    end
    tot = 2 + nx + ny;
    for (int k = 0; k < nx; k++) plrez_q.push_back(av[k]);
    for (int k = 0; k < ny; k++) plrez_q.push_back(bv[k]);
    res_q.push_back(32'(av) * xv + 32'(bv) * yv);

    @(negedge clk);
    chk({name, " idle_before"}, 32'(obs_vec(i)), 32'(exp_vec(0, 1'b0)));
    a_v[i] = av;
    b_v[i] = bv;
    x0[i] = xv;
    y0[i] = yv;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    a_v[i] = 8'h5A;
    b_v[i] = 8'hA5;

    for (int n = 1; n <= tot + 1; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 1) ph = 1;
      else if (n <= 1 + nx) ph = 2;
      else if (n <= 1 + nx + ny) ph = 3;
      else if (n == tot) ph = 4;
      else ph = 0;
      pr = 1'b0;
      if (ph == 2 || ph == 3) begin
        if (plrez_q.size() == 0) chk({name, " plrez_queue_empty"}, 32'd1, 32'd0);
        else pr = plrez_q.pop_front();
      end
      chk($sformatf("%s cycle%0d", name, n), 32'(obs_vec(i)), 32'(exp_vec(ph, pr)));
      if (ph == 4) begin
        if (res_q.size() == 0) chk({name, " result_queue_empty"}, 32'd1, 32'd0);
        else begin
          er = res_q.pop_front();
          chk({name, " result"}, rez[i], er);
        end
      end
      if (ign && n == 3) begin
        start_v[i] = 1'b1;
        a_v[i] = 8'hFF;
        b_v[i] = 8'hFF;
      end else if (ign && n == 4) begin
        start_v[i] = 1'b0;
      end
      if (rst_mid && n == 4 + nx) begin
        reset = 1'b1;
        #1;
        chk({name, " async_reset"}, 32'(obs_vec(i)), 32'(exp_vec(0, 1'b0)));
        @(negedge clk);
        chk({name, " reset_hold"}, 32'(obs_vec(i)), 32'(exp_vec(0, 1'b0)));
        reset = 1'b0;
        plrez_q.delete();
        res_q.delete();
        repeat (3) begin
          @(negedge clk);
          chk({name, " no_done_after_reset"}, 32'(obs_vec(i)), 32'(exp_vec(0, 1'b0)));
        end
        return;
      end
    end
    if (plrez_q.size() != 0) chk({name, " plrez_queue_leftover"}, 32'(plrez_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start_v = 2'b11;
    a_v = '{8'h12, 8'h34};
    b_v = '{8'h56, 8'h78};
    x0 = '0;
    y0 = '0;
    // Reset with start held high: must stay in IDLE
    repeat (2) begin
      @(negedge clk);
      chk("reset dut0", 32'(obs_vec(0)), 32'(exp_vec(0, 1'b0)));
      chk("reset dut1", 32'(obs_vec(1)), 32'(exp_vec(0, 1'b0)));
    end
    start_v = 2'b00;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset dut0", 32'(obs_vec(0)), 32'(exp_vec(0, 1'b0)));

    run_op(0, 8'd3,  8'd5,  32'd10, 32'd20, 1'b0, 1'b0, "basic");
    run_op(0, 8'hFF, 8'h80, 32'd1,  32'd1,  1'b0, 1'b0, "full");
    run_op(0, 8'd3,  8'd5,  32'd10, 32'd20, 1'b1, 1'b0, "ignored_start");
    run_op(1, 8'h00, 8'h00, 32'd7,  32'd9,  1'b0, 1'b0, "skip_zero");
    run_op(1, 8'h01, 8'h80, 32'd3,  32'd2,  1'b0, 1'b0, "skip_lo_hi");
    run_op(1, 8'd3,  8'd5,  32'd10, 32'd20, 1'b0, 1'b0, "skip_basic");
    run_op(0, 8'hFF, 8'hFF, 32'd1,  32'd1,  1'b0, 1'b1, "reset_mid");
    run_op(0, 8'd3,  8'd5,  32'd10, 32'd20, 1'b0, 1'b0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
